// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW hazard detection, multi-cycle
// branch flush, memory-busy freeze with sticky timeout, and saturating perf counters.
module pipe_hazard_ctrl #(
  parameter bit          FWD_EN       = 1'b1,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  src1,
  input  logic [4:0]  src2,
  input  logic        two_src,
  input  logic [4:0]  exe_dest,
  input  logic        exe_wb_en,
  input  logic        exe_mem_r_en,
  input  logic [4:0]  mem_dest,
  input  logic        mem_wb_en,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic        freeze_pc,
  output logic        freeze_if_id,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        hold_exe,
  output logic        mem_timeout,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {StRun, StBranch, StMemWait} state_e;

  localparam logic [2:0] FlushInit  = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] MemTimeout = 8'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [2:0]  flush_left_q, flush_left_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic freeze_pc_c, freeze_if_id_c, flush_if_id_c, flush_id_ex_c, hold_exe_c;
  logic branch_flush;
  logic flushing;
  logic hazard;

  function automatic logic src_hit(input logic [4:0] src);
    logic exe_hit;
    logic mem_hit;
    exe_hit = exe_wb_en && (exe_dest != 5'd0) && (exe_dest == src) &&
              (!FWD_EN || exe_mem_r_en);
    mem_hit = !FWD_EN && mem_wb_en && (mem_dest != 5'd0) && (mem_dest == src);
    return exe_hit || mem_hit;
  endfunction

  assign hazard = src_hit(src1) || (two_src && src_hit(src2));

  // A memory wait that interrupted a branch resumes the remaining flush cycles.
  assign flushing = (state_q == StBranch) ||
                    ((state_q == StMemWait) && (flush_left_q != 3'd0));

  always_comb begin
    state_d        = state_q;
    flush_left_d   = flush_left_q;
    wait_cnt_d     = wait_cnt_q;
    freeze_pc_c    = 1'b0;
    freeze_if_id_c = 1'b0;
    flush_if_id_c  = 1'b0;
    flush_id_ex_c  = 1'b0;
    hold_exe_c     = 1'b0;
    branch_flush   = 1'b0;

    if (mem_busy) begin
      freeze_pc_c    = 1'b1;
      freeze_if_id_c = 1'b1;
      hold_exe_c     = 1'b1;
      state_d        = StMemWait;
      if (state_q == StMemWait) begin
        wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
      end else begin
        wait_cnt_d = 8'd1;
      end
    end else begin
      wait_cnt_d = 8'd0;
      state_d    = StRun;
      if (flushing) begin
        flush_if_id_c = 1'b1;
        flush_id_ex_c = 1'b1;
        branch_flush  = 1'b1;
        flush_left_d  = flush_left_q - 3'd1;
        if (flush_left_q != 3'd1) state_d = StBranch;
      end else if (branch_taken) begin
        flush_if_id_c = 1'b1;
        flush_id_ex_c = 1'b1;
        branch_flush  = 1'b1;
        flush_left_d  = FlushInit;
        if (FlushInit != 3'd0) state_d = StBranch;
      end else if (hazard) begin
        freeze_pc_c    = 1'b1;
        freeze_if_id_c = 1'b1;
        flush_id_ex_c  = 1'b1;
      end
    end
  end

  always_comb begin
    mem_timeout_d = mem_timeout_q || (mem_busy && (wait_cnt_d >= MemTimeout));
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    if (freeze_pc_c && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (branch_flush && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StRun;
      flush_left_q  <= 3'd0;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= 16'd0;
      flush_cnt_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      flush_left_q  <= flush_left_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  // Controls are Mealy; gate with reset so they are quiet while rst is low.
  assign freeze_pc    = rst && freeze_pc_c;
  assign freeze_if_id = rst && freeze_if_id_c;
  assign flush_if_id  = rst && flush_if_id_c;
  assign flush_id_ex  = rst && flush_id_ex_c;
  assign hold_exe     = rst && hold_exe_c;
  assign mem_timeout  = mem_timeout_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two configurations side by side, directed scenarios plus
// randomized traffic checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] src1, src2, exe_dest, mem_dest;
  logic       two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, branch_taken, mem_busy;

  logic        fpc_a, fifid_a, flifid_a, flidex_a, hold_a, to_a;
  logic        fpc_b, fifid_b, flifid_b, flidex_b, hold_b, to_b;
  logic [15:0] stall_a, flush_a, stall_b, flush_b;
  logic [4:0]  ctl_a, ctl_b;

  // ctl vectors: {freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, hold_exe}
  localparam logic [4:0] CtlNone  = 5'b00000;
  localparam logic [4:0] CtlStall = 5'b11010;
  localparam logic [4:0] CtlFlush = 5'b00110;
  localparam logic [4:0] CtlHold  = 5'b11001;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_hazard_ctrl #(.FWD_EN(1'b1), .FLUSH_CYCLES(3), .MEM_TIMEOUT(3)) dut_a (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .freeze_pc(fpc_a), .freeze_if_id(fifid_a),
    .flush_if_id(flifid_a), .flush_id_ex(flidex_a), .hold_exe(hold_a),
    .mem_timeout(to_a), .stall_cnt(stall_a), .flush_cnt(flush_a)
  );

  pipe_hazard_ctrl #(.FWD_EN(1'b0), .FLUSH_CYCLES(1), .MEM_TIMEOUT(255)) dut_b (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .freeze_pc(fpc_b), .freeze_if_id(fifid_b),
    .flush_if_id(flifid_b), .flush_id_ex(flidex_b), .hold_exe(hold_b),
    .mem_timeout(to_b), .stall_cnt(stall_b), .flush_cnt(flush_b)
  );

  assign ctl_a = {fpc_a, fifid_a, flifid_a, flidex_a, hold_a};
  assign ctl_b = {fpc_b, fifid_b, flifid_b, flidex_b, hold_b};

  always #5 clk = ~clk;

  // Behavioural model: index 0 mirrors dut_a's configuration, index 1 dut_b's.
  bit p_fwd [2] = '{1'b1, 1'b0};
  int p_fc  [2] = '{3, 1};
  int p_mt  [2] = '{3, 255};
  int m_fl   [2];
  int m_wait [2];
  bit m_to   [2];
  int m_stall[2];
  int m_flush[2];

  function automatic bit m_hit(input int k, input logic [4:0] s);
    bit e, m;
    e = exe_wb_en && (exe_dest != 0) && (exe_dest == s) && (exe_mem_r_en || !p_fwd[k]);
    m = !p_fwd[k] && mem_wb_en && (mem_dest != 0) && (mem_dest == s);
    return e || m;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_fl[k] = 0; m_wait[k] = 0; m_to[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
    end
  endtask

  // Returns this cycle's expected controls and advances the model past the next edge.
  task automatic model_cycle(input int k, output logic [4:0] ctl);
    bit br;
    bit hz;
    ctl = CtlNone;
    br  = 0;
    hz  = m_hit(k, src1) || (two_src && m_hit(k, src2));
    if (mem_busy) begin
      ctl = CtlHold;
      if (m_wait[k] == 0) m_wait[k] = 1;
      else if (m_wait[k] < 255) m_wait[k] = m_wait[k] + 1;
      if (m_wait[k] >= p_mt[k]) m_to[k] = 1;
    end else begin
      m_wait[k] = 0;
      if (m_fl[k] > 0) begin
        ctl = CtlFlush; br = 1; m_fl[k] = m_fl[k] - 1;
      end else if (branch_taken) begin
        ctl = CtlFlush; br = 1; m_fl[k] = p_fc[k] - 1;
      end else if (hz) begin
        ctl = CtlStall;
      end
    end
    if (ctl[4] && m_stall[k] < 65535) m_stall[k] = m_stall[k] + 1;
    if (br && m_flush[k] < 65535) m_flush[k] = m_flush[k] + 1;
  endtask

  task automatic idle();
    src1 = 0; src2 = 0; two_src = 0; exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0;
    mem_dest = 0; mem_wb_en = 0; branch_taken = 0; mem_busy = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    #2;
    n_checks++; if (ctl_a !== CtlNone || ctl_b !== CtlNone)
      $display("FAIL reset_ctl: got %b/%b want %b", ctl_a, ctl_b, CtlNone); else n_pass++;
    n_checks++; if (stall_a !== 0 || flush_a !== 0 || to_a !== 0)
      $display("FAIL reset_regs: got %0d %0d %b want 0 0 0", stall_a, flush_a, to_a);
    else n_pass++;
    branch_taken = 1; mem_busy = 1; exe_wb_en = 1; exe_dest = 3; src1 = 3;
    #1;
    n_checks++; if (ctl_a !== CtlNone || ctl_b !== CtlNone)
      $display("FAIL reset_gated: got %b/%b want %b", ctl_a, ctl_b, CtlNone); else n_pass++;
    tick();
    n_checks++; if (stall_b !== 0 || to_a !== 0)
      $display("FAIL reset_held: got %0d %b want 0 0", stall_b, to_a); else n_pass++;
    idle();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    do_reset(); idle();
    exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 5; src1 = 5;
    #1;
    n_checks++; if (ctl_a !== CtlStall)
      $display("FAIL load_use_stall: got %b want %b", ctl_a, CtlStall); else n_pass++;
    tick(); idle(); #1;
    n_checks++; if (stall_a !== 16'd1 || ctl_a !== CtlNone)
      $display("FAIL load_use_after: got %0d %b want 1 %b", stall_a, ctl_a, CtlNone);
    else n_pass++;
    exe_wb_en = 1; exe_mem_r_en = 0; exe_dest = 5; src1 = 5;
    #1;
    n_checks++; if (ctl_a !== CtlNone)
      $display("FAIL fwd_no_stall: got %b want %b", ctl_a, CtlNone); else n_pass++;
    n_checks++; if (ctl_b !== CtlStall)
      $display("FAIL nofwd_exe_stall: got %b want %b", ctl_b, CtlStall); else n_pass++;
    tick(); idle();
  endtask

  task automatic test_no_fwd();
    do_reset(); idle();
    mem_wb_en = 1; mem_dest = 7; two_src = 1; src2 = 7;
    #1;
    n_checks++; if (ctl_b !== CtlStall)
      $display("FAIL nofwd_mem_src2: got %b want %b", ctl_b, CtlStall); else n_pass++;
    n_checks++; if (ctl_a !== CtlNone)
      $display("FAIL fwd_mem_ignored: got %b want %b", ctl_a, CtlNone); else n_pass++;
    two_src = 0;
    #1;
    n_checks++; if (ctl_b !== CtlNone)
      $display("FAIL nofwd_one_src: got %b want %b", ctl_b, CtlNone); else n_pass++;
    two_src = 1; mem_dest = 0; src2 = 0;
    #1;
    n_checks++; if (ctl_b !== CtlNone)
      $display("FAIL nofwd_reg0: got %b want %b", ctl_b, CtlNone); else n_pass++;
    tick(); idle();
  endtask

  task automatic test_branch();
    do_reset(); idle();
    exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 5; src1 = 5; branch_taken = 1;
    #1;
    n_checks++; if (ctl_a !== CtlFlush || ctl_b !== CtlFlush)
      $display("FAIL branch_wins: got %b/%b want %b", ctl_a, ctl_b, CtlFlush); else n_pass++;
    tick(); branch_taken = 0; #1;
    n_checks++; if (ctl_a !== CtlFlush)
      $display("FAIL branch_c1: got %b want %b", ctl_a, CtlFlush); else n_pass++;
    n_checks++; if (ctl_b !== CtlStall)
      $display("FAIL branch1_done: got %b want %b", ctl_b, CtlStall); else n_pass++;
    tick(); #1;
    n_checks++; if (ctl_a !== CtlFlush)
      $display("FAIL branch_c2: got %b want %b", ctl_a, CtlFlush); else n_pass++;
    tick(); #1;
    n_checks++; if (ctl_a !== CtlStall)
      $display("FAIL branch_back_run: got %b want %b", ctl_a, CtlStall); else n_pass++;
    tick(); idle(); #1;
    n_checks++; if (flush_a !== 16'd3 || stall_a !== 16'd1 || ctl_a !== CtlNone)
      $display("FAIL branch_counts: got %0d %0d %b want 3 1 %b",
               flush_a, stall_a, ctl_a, CtlNone);
    else n_pass++;
  endtask

  task automatic test_mem_branch();
    do_reset(); idle();
    branch_taken = 1;
    #1;
    n_checks++; if (ctl_a !== CtlFlush)
      $display("FAIL mb_c0: got %b want %b", ctl_a, CtlFlush); else n_pass++;
    tick(); branch_taken = 0; #1;
    n_checks++; if (ctl_a !== CtlFlush)
      $display("FAIL mb_c1: got %b want %b", ctl_a, CtlFlush); else n_pass++;
    tick();
    mem_busy = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (ctl_a !== CtlHold)
        $display("FAIL mb_hold%0d: got %b want %b", i, ctl_a, CtlHold); else n_pass++;
      tick();
    end
    mem_busy = 0;
    #1;
    n_checks++; if (ctl_a !== CtlFlush)
      $display("FAIL mb_resume: got %b want %b", ctl_a, CtlFlush); else n_pass++;
    tick(); #1;
    n_checks++; if (ctl_a !== CtlNone || stall_a !== 16'd4 || flush_a !== 16'd3)
      $display("FAIL mb_end: got %b %0d %0d want %b 4 3", ctl_a, stall_a, flush_a, CtlNone);
    else n_pass++;
    n_checks++; if (stall_b !== 16'd4 || flush_b !== 16'd1)
      $display("FAIL mb_end_b: got %0d %0d want 4 1", stall_b, flush_b); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset(); idle();
    mem_busy = 1;
    for (int k = 1; k <= 5; k++) begin
      #1;
      n_checks++; if (to_a !== (k >= 4) || ctl_a !== CtlHold)
        $display("FAIL timeout_busy%0d: got %b %b want %b %b", k, to_a, ctl_a,
                 (k >= 4), CtlHold);
      else n_pass++;
      tick();
    end
    mem_busy = 0;
    tick(); tick(); #1;
    n_checks++; if (to_a !== 1'b1 || to_b !== 1'b0)
      $display("FAIL timeout_sticky: got %b/%b want 1/0", to_a, to_b); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (to_a !== 1'b0)
      $display("FAIL timeout_clear: got %b want 0", to_a); else n_pass++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset(); idle();
    mem_busy = 1;
    tick(); tick(); #1;
    rst = 1'b0;
    #1;
    n_checks++; if (ctl_a !== CtlNone || ctl_b !== CtlNone || stall_a !== 16'd0)
      $display("FAIL rst_memwait: got %b/%b %0d want %b/%b 0", ctl_a, ctl_b, stall_a,
               CtlNone, CtlNone);
    else n_pass++;
    rst = 1'b1;
    tick(); tick(); #1;
    n_checks++; if (to_a !== 1'b0 || stall_a !== 16'd2)
      $display("FAIL rst_wait_cleared: got %b %0d want 0 2", to_a, stall_a); else n_pass++;
    do_reset(); idle();
    branch_taken = 1;
    tick(); branch_taken = 0; #1;
    rst = 1'b0;
    #1;
    n_checks++; if (ctl_a !== CtlNone || flush_a !== 16'd0)
      $display("FAIL rst_branch: got %b %0d want %b 0", ctl_a, flush_a, CtlNone);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (ctl_a !== CtlNone)
      $display("FAIL rst_branch_idle: got %b want %b", ctl_a, CtlNone); else n_pass++;
    tick(); #1;
    n_checks++; if (ctl_a !== CtlNone || flush_a !== 16'd0 || stall_a !== 16'd0)
      $display("FAIL rst_branch_after: got %b %0d %0d want %b 0 0", ctl_a, flush_a,
               stall_a, CtlNone);
    else n_pass++;
  endtask

  task automatic test_random();
    int         burst;
    logic [4:0] exp_ctl;
    logic [4:0] got_ctl;
    logic       got_to;
    logic [15:0] got_stall, got_flush;
    do_reset(); idle(); model_reset();
    burst = 0;
    for (int i = 0; i < 600; i++) begin
      src1         = 5'($urandom_range(0, 3));
      src2         = 5'($urandom_range(0, 3));
      two_src      = 1'($urandom_range(0, 1));
      exe_dest     = 5'($urandom_range(0, 3));
      exe_wb_en    = 1'($urandom_range(0, 1));
      exe_mem_r_en = 1'($urandom_range(0, 1));
      mem_dest     = 5'($urandom_range(0, 3));
      mem_wb_en    = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 7) == 0);
      if (burst == 0 && $urandom_range(0, 9) == 0) burst = $urandom_range(1, 5);
      mem_busy = (burst > 0);
      if (burst > 0) burst--;
      #1;
      for (int k = 0; k < 2; k++) begin
        got_ctl   = (k == 0) ? ctl_a : ctl_b;
        got_to    = (k == 0) ? to_a : to_b;
        got_stall = (k == 0) ? stall_a : stall_b;
        got_flush = (k == 0) ? flush_a : flush_b;
        n_checks++; if (got_to !== m_to[k] || got_stall !== 16'(m_stall[k]) ||
                        got_flush !== 16'(m_flush[k]))
          $display("FAIL rand_regs dut%0d cyc %0d: got %b %0d %0d want %b %0d %0d", k, i,
                   got_to, got_stall, got_flush, m_to[k], m_stall[k], m_flush[k]);
        else n_pass++;
        model_cycle(k, exp_ctl);
        n_checks++; if (got_ctl !== exp_ctl)
          $display("FAIL rand_ctl dut%0d cyc %0d: got %b want %b", k, i, got_ctl, exp_ctl);
        else n_pass++;
      end
      tick();
    end
    idle();
  endtask

  task automatic test_saturate();
    do_reset(); idle();
    exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 5; src1 = 5;
    repeat (65534) @(posedge clk);
    #1;
    n_checks++; if (stall_a !== 16'hFFFE)
      $display("FAIL sat_pre: got %h want fffe", stall_a); else n_pass++;
    tick();
    n_checks++; if (stall_a !== 16'hFFFF || stall_b !== 16'hFFFF)
      $display("FAIL sat_reach: got %h/%h want ffff", stall_a, stall_b); else n_pass++;
    repeat (5) tick();
    n_checks++; if (stall_a !== 16'hFFFF || ctl_a !== CtlStall || flush_a !== 16'd0)
      $display("FAIL sat_hold: got %h %b %0d want ffff %b 0", stall_a, ctl_a, flush_a,
               CtlStall);
    else n_pass++;
    idle();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_use();
    test_no_fwd();
    test_branch();
    test_mem_branch();
    test_timeout();
    test_async_reset();
    test_random();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Detects RAW hazards between the instruction in ID and the instructions in EXE/MEM.
- Sequences multi-cycle branch flushes and freezes the whole pipe while data memory is busy.
- Drives freeze/flush controls of the PC, IF/ID, ID/EX and EXE/MEM registers; keeps saturating stall/flush performance counters.

Parameters:
- FWD_EN, 1: 1 = forwarding present, only load-use hazards stall. 0 = any RAW against EXE or MEM stalls.
- FLUSH_CYCLES, 1: number of cycles IF/ID and ID/EX are flushed per taken branch (1..7).
- MEM_TIMEOUT, 255: mem_busy cycles tolerated before mem_timeout is raised (1..255).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- src1  in  5  ID-stage source register 1.
- src2  in  5  ID-stage source register 2.
- two_src  in  1  ID instruction reads src2.
- exe_dest  in  5  destination in ID/EX register.
- exe_wb_en  in  1  EXE instruction writes back.
- exe_mem_r_en  in  1  EXE instruction is a load.
- mem_dest  in  5  destination in EXE/MEM register.
- mem_wb_en  in  1  MEM instruction writes back.
- branch_taken  in  1  taken branch resolved in EXE.
- mem_busy  in  1  data memory not ready this cycle.
- freeze_pc  out  1  hold PC.
- freeze_if_id  out  1  hold IF/ID.
- flush_if_id  out  1  clear IF/ID on next edge.
- flush_id_ex  out  1  insert bubble into ID/EX on next edge.
- hold_exe  out  1  hold ID/EX and EXE/MEM.
- mem_timeout  out  1  sticky error flag.
- stall_cnt  out  16  freeze_pc cycles, saturating.
- flush_cnt  out  16  branch-flush cycles, saturating.

Behaviour:
- Hazard term (combinational), for each of src1 and src2 (src2 only when two_src=1):
  - EXE match: exe_wb_en & exe_dest!=0 & exe_dest==src, qualified by exe_mem_r_en when FWD_EN=1.
  - MEM match (FWD_EN=0 only): mem_wb_en & mem_dest!=0 & mem_dest==src.
  - Register 0 never causes a hazard.
- FSM states: RUN, BRANCH, MEMWAIT; encoding is free. Control outputs are Mealy (state + inputs, same cycle). Priority in every state: mem_busy > branch/flush > hazard.
- RUN:
  - mem_busy=1: freeze_pc=freeze_if_id=hold_exe=1 -> MEMWAIT; wait_cnt=1.
  - Else branch_taken=1: flush_if_id=flush_id_ex=1; flush_left=FLUSH_CYCLES-1; -> BRANCH if flush_left>0, else stay in RUN.
  - Else hazard: freeze_pc=freeze_if_id=1, flush_id_ex=1 (bubble).
  - Else all controls 0.
- BRANCH:
  - mem_busy=1: as RUN's mem_busy case, flush_left preserved, -> MEMWAIT.
  - Else flush_if_id=flush_id_ex=1, flush_left decrements; -> RUN when flush_left reaches 0 on this cycle.
  - branch_taken and hazard are ignored in BRANCH.
- MEMWAIT:
  - mem_busy=1: freeze_pc=freeze_if_id=hold_exe=1; wait_cnt increments, saturating at 255.
  - When wait_cnt reaches MEM_TIMEOUT with mem_busy still 1: mem_timeout<=1, sticky until reset.
  - mem_busy=0: no hold this cycle. If flush_left>0, behave as BRANCH (same cycle), else behave as RUN including RUN's transitions; wait_cnt<=0.
- Counters:
  - stall_cnt +1 on each edge where freeze_pc=1.
  - flush_cnt +1 on each edge where the flush is branch-caused (not hazard bubbles).
  - Both saturate at 16'hFFFF, no wrap.
- Reset (rst=0, asynchronous, any state incl. mid-flush or mid-wait):
  - state=RUN, flush_left=0, wait_cnt=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
  - All control outputs 0 while rst=0, regardless of inputs.
- Simultaneous hazard + branch_taken: branch wins; only the flush is asserted, no freeze.

Test Plan:
- Load-use, FWD_EN=1: exe_mem_r_en=1, exe_dest=5, src1=5 -> freeze_pc=freeze_if_id=flush_id_ex=1 for one cycle; stall_cnt=1. Same with exe_mem_r_en=0 -> no controls.
- FWD_EN=0, mem_wb_en=1, mem_dest=7, two_src=1, src2=7 -> stall asserted. src2=7 with two_src=0, or dest=0 -> no stall.
- FLUSH_CYCLES=3, branch_taken pulse -> flush_if_id=flush_id_ex=1 for exactly 3 cycles, back to RUN; flush_cnt=3. Hazard during those cycles -> no freeze.
- mem_busy high 4 cycles mid-branch (flush_left=1) -> hold_exe/freeze high 4 cycles, then 1 flush cycle, then RUN; stall_cnt=4.
- MEM_TIMEOUT=3, mem_busy held 5 cycles -> mem_timeout rises after the 3rd busy cycle and stays 1 after mem_busy drops; clears only on rst=0.
- rst asserted mid-MEMWAIT and mid-BRANCH -> outputs 0 immediately (asynchronous); after release, idle RUN with counters 0. Force stall_cnt to 16'hFFFF -> remains 16'hFFFF under further stalls.
